// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   arbState_t       - arbiter FSM state encoding (HOLD is only reachable when
//                      the packet-lock option UART_TX_ARB_LOCK_EN is compiled in)
//   NUM_REQ_DEFAULT  - default number of byte producers
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int NUM_REQ_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        HOLD      = 3'd3
    } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search: finds the first set bit of reqValid
// scanning circularly upward from lastGrant+1, so lastGrant itself is checked
// last and gets the lowest priority.
// Ports:
//   reqValid  in  NUM_REQ  per-requester request bits
//   lastGrant in  GW       index granted most recently
//   found     out 1        at least one request is pending
//   index     out GW       winning requester (0 when found==0)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [GW-1:0]      lastGrant,
    output logic               found,
    output logic [GW-1:0]      index
);

    int          cand;
    logic [GW-1:0] candIdx;

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        found   = 1'b0;
        index   = '0;
        cand    = 0;
        candIdx = '0;
        // Offsets 1..NUM_REQ; the first hit is the nearest requester after
        // lastGrant, and the found guard keeps later hits from overriding it.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand    = (int'(lastGrant) + off) % NUM_REQ;
            candIdx = GW'(cand);
            if (!found && reqValid[candIdx]) begin
                found = 1'b1;
                index = candIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers. A byte is accepted
// with a one-hot reqReady pulse, launched with a one-cycle txDv the next cycle,
// and the transmitter is then owned until its txDone pulse. Grants rotate
// round-robin; txActive gates every new accept so a frame still in flight from
// before a reset is never overrun.
// Optional feature: define UART_TX_ARB_LOCK_EN for packet lock - after a byte
// with reqLast==0 completes, only the same requester is served (HOLD state)
// until its reqLast==1 byte has completed.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   reqValid/reqData   per-requester byte offer (byte i at [8i+7:8i])
//   reqLast            last byte of a packet (lock feature only)
//   reqReady           one-hot accept strobe (combinational)
//   txDv, txData       launch pulse and byte to the transmitter
//   txActive, txDone   transmitter busy flag and completion pulse
//   grantId            current/last granted requester
//   busy               arbiter is not in IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [NUM_REQ*8-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqLast,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic                 txDv,
    output logic [7:0]           txData,
    input  logic                 txActive,
    input  logic                 txDone,
    output logic [GW-1:0]        grantId,
    output logic                 busy
);

    arbState_t     state, nextState;
    logic [GW-1:0] lastGrant;
    logic          pickFound;
    logic [GW-1:0] pickIdx;
    logic          accept;
    logic [GW-1:0] acceptIdx;

`ifdef UART_TX_ARB_LOCK_EN
    logic          lastFlag;   // reqLast of the byte currently owned
`else
    logic          unusedLast;
    assign unusedLast = ^reqLast;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) picker (
        .reqValid  (reqValid),
        .lastGrant (lastGrant),
        .found     (pickFound),
        .index     (pickIdx)
    );

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        acceptIdx = pickIdx;
        case (state)
            IDLE: begin
                if (pickFound && !txActive) begin
                    accept    = 1'b1;
                    nextState = LAUNCH;
                end
            end
            LAUNCH: nextState = WAIT_DONE;
            WAIT_DONE: begin
                if (txDone) begin
`ifdef UART_TX_ARB_LOCK_EN
                    nextState = lastFlag ? IDLE : HOLD;
`else
                    nextState = IDLE;
`endif
                end
            end
`ifdef UART_TX_ARB_LOCK_EN
            HOLD: begin
                // Only the locked requester may continue its packet.
                acceptIdx = grantId;
                if (reqValid[grantId] && !txActive) begin
                    accept    = 1'b1;
                    nextState = LAUNCH;
                end
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        reqReady = '0;
        if (accept) begin
            reqReady[acceptIdx] = 1'b1;
        end
    end

    // txDv and busy come straight from the state register, so txDone and
    // txActive have no combinational path to the launch pulse.
    assign txDv = (state == LAUNCH);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            txData    <= 8'h00;
            grantId   <= '0;
            lastGrant <= GW'(NUM_REQ - 1);   // requester 0 wins first
`ifdef UART_TX_ARB_LOCK_EN
            lastFlag  <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if (accept) begin
                txData  <= reqData[{acceptIdx, 3'b000} +: 8];
                grantId <= acceptIdx;
`ifdef UART_TX_ARB_LOCK_EN
                lastFlag <= reqLast[acceptIdx];
`endif
            end
            if (state == WAIT_DONE && txDone) begin
`ifdef UART_TX_ARB_LOCK_EN
                // Rotation only moves on once a whole packet has gone out.
                if (lastFlag) begin
                    lastGrant <= grantId;
                end
`else
                lastGrant <= grantId;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4). Stimulus pushes bytes into
// per-requester queues and pushes the hand-ordered expected launches into a
// scoreboard queue; a monitor pops and compares on every txDv. A small
// transmitter model answers each launch with txActive and a txDone pulse.
// Define UART_TX_ARB_LOCK_EN to exercise the packet-lock build.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int GW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   reqValid;
    logic [N*8-1:0] reqData;
    logic [N-1:0]   reqLast;
    logic [N-1:0]   reqReady;
    logic           txDv;
    logic [7:0]     txData;
    logic           txActive;
    logic           txDone;
    logic [GW-1:0]  grantId;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqReady (reqReady),
        .txDv     (txDv),
        .txData   (txData),
        .txActive (txActive),
        .txDone   (txDone),
        .grantId  (grantId),
        .busy     (busy)
    );

    typedef struct packed { logic [7:0] data; logic last; } reqItem_t;
    typedef struct packed { logic [7:0] data; logic [GW-1:0] id; } expItem_t;

    reqItem_t reqQ[N][$];
    expItem_t expQ[$];
    int errors = 0;
    int checks = 0;

    logic [N-1:0] readySeen;
    logic autoTx, modelActive, modelDone, manualActive, manualDone;
    assign txActive = modelActive | manualActive;
    assign txDone   = modelDone | manualDone;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushReq(input int idx, input logic [7:0] d, input logic last);
        reqItem_t it;
        it.data = d;
        it.last = last;
        reqQ[idx].push_back(it);
    endtask

    task automatic expectTx(input logic [7:0] d, input int id);
        expItem_t e;
        e.data = d;
        e.id   = GW'(id);
        expQ.push_back(e);
    endtask

    task automatic waitReady(input int idx, input string name);
        logic [N-1:0] want;
        want = '0;
        want[idx] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (reqReady != '0) break;
        end
        check(name, 32'(reqReady), 32'(want));
    endtask

    task automatic waitDrain(input string name);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            done = (expQ.size() == 0) && !busy && !txActive &&
                   (reqQ[0].size() == 0) && (reqQ[1].size() == 0) &&
                   (reqQ[2].size() == 0) && (reqQ[3].size() == 0);
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, 32'(reqReady), 32'd0);
        check({tag, "_txdv"},  32'(txDv),     32'd0);
        check({tag, "_data"},  32'(txData),   32'h00);
        check({tag, "_grant"}, 32'(grantId),  32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
    endtask

    task automatic pulseReset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Requester driver: each requester offers the head of its queue and
    // retires it after the accept seen in the previous cycle.
    initial begin
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (readySeen[i] && reqQ[i].size() > 0) begin
                    reqQ[i].delete(0);
                end
                if (reqQ[i].size() > 0) begin
                    reqValid[i]      = 1'b1;
                    reqData[i*8 +: 8] = reqQ[i][0].data;
                    reqLast[i]       = reqQ[i][0].last;
                end else begin
                    reqValid[i] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: busy for a few cycles after each launch, then a
    // one-cycle txDone together with txActive falling.
    initial begin
        modelActive = 1'b0;
        modelDone   = 1'b0;
        forever begin
            @(negedge clk);
            if (autoTx && txDv && !reset) begin
                @(posedge clk); #1 modelActive = 1'b1;
                repeat (6) @(posedge clk);
                #1 modelDone = 1'b1;
                modelActive = 1'b0;
                @(posedge clk); #1 modelDone = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [N-1:0] prevReady;
        expItem_t e;
        prevReady = '0;
        readySeen = '0;
        forever begin
            @(negedge clk);
            readySeen = reset ? '0 : reqReady;
            if (reset) begin
                prevReady = '0;
            end else begin
                if (prevReady != '0) check("launch_after_ready", 32'(txDv), 32'd1);
                if (txDv) begin
                    check("ready_before_launch", 32'(prevReady != '0), 32'd1);
                    if (expQ.size() == 0) begin
                        check("unexpected_launch", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("tx_data",  32'(txData),  32'(e.data));
                        check("grant_id", 32'(grantId), 32'(e.id));
                    end
                end
                if (reqReady != '0) begin
                    check("ready_onehot", 32'($onehot(reqReady)), 32'd1);
`ifndef UART_TX_ARB_LOCK_EN
                    check("ready_only_idle", 32'(busy), 32'd0);
`endif
                end
                prevReady = reqReady;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int doneAt;
        int n;
        logic bad;

        reset        = 1'b1;
        autoTx       = 1'b1;
        manualActive = 1'b0;
        manualDone   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Single requester, then a second byte must wait for txDone.
        pushReq(0, 8'hA5, 1'b1);
        expectTx(8'hA5, 0);
        waitReady(0, "single_ready");
        pushReq(0, 8'h5A, 1'b1);
        expectTx(8'h5A, 0);
        doneAt = -1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (txDone) doneAt = n;
            if (reqReady != '0) break;
        end
        check("gap_after_done", 32'(n), 32'(doneAt + 1));
        waitDrain("drain_single");

        // Fairness: all four continuously valid.
        pulseReset();
        pushReq(0, 8'h10, 1'b1);
        pushReq(0, 8'h10, 1'b1);
        pushReq(1, 8'h11, 1'b1);
        pushReq(2, 8'h12, 1'b1);
        pushReq(3, 8'h13, 1'b1);
        expectTx(8'h10, 0);
        expectTx(8'h11, 1);
        expectTx(8'h12, 2);
        expectTx(8'h13, 3);
        expectTx(8'h10, 0);
        waitDrain("drain_rotate");

        // Transmitter busy for 20 cycles blocks the grant.
        @(posedge clk); #1 manualActive = 1'b1;
        pushReq(2, 8'h5C, 1'b1);
        expectTx(8'h5C, 2);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (reqReady != '0 || txDv) bad = 1'b1;
        end
        check("busy_blocks", 32'(bad), 32'd0);
        @(posedge clk); #1 manualActive = 1'b0;
        @(negedge clk);
        check("ready_after_active_falls", 32'(reqReady), 32'b0100);
        waitDrain("drain_busy");

        // Reset in WAIT_DONE while the transmitter is still active.
        @(posedge clk); #1 autoTx = 1'b0;
        pushReq(2, 8'h77, 1'b1);
        expectTx(8'h77, 2);
        waitReady(2, "pre_reset_ready");
        @(posedge clk); #1 manualActive = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        pushReq(0, 8'h0A, 1'b1);
        pushReq(2, 8'h2B, 1'b1);
        expectTx(8'h0A, 0);
        expectTx(8'h2B, 2);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkResetOutputs("midreset");
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (reqReady != '0 || txDv) bad = 1'b1;
        end
        check("no_launch_while_active", 32'(bad), 32'd0);
        @(posedge clk); #1 manualActive = 1'b0;
        autoTx = 1'b1;
        @(negedge clk);
        check("reset_priority", 32'(reqReady), 32'b0001);
        waitDrain("drain_reset");

        // Stray txDone in IDLE is ignored.
        @(posedge clk); #1 manualDone = 1'b1;
        @(posedge clk); #1 manualDone = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy || txDv || reqReady != '0) bad = 1'b1;
        end
        check("done_in_idle", 32'(bad), 32'd0);
        check("done_in_idle_data", 32'(txData), 32'h2B);

        // Three-byte packet from requester 1 competing with requester 2.
        pulseReset();
        pushReq(1, 8'h31, 1'b0);
        pushReq(1, 8'h32, 1'b0);
        pushReq(1, 8'h33, 1'b1);
        pushReq(2, 8'h40, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
        expectTx(8'h31, 1);
        expectTx(8'h32, 1);
        expectTx(8'h33, 1);
        expectTx(8'h40, 2);
`else
        expectTx(8'h31, 1);
        expectTx(8'h40, 2);
        expectTx(8'h32, 1);
        expectTx(8'h33, 1);
`endif
        waitDrain("drain_packet");

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. It accepts bytes through per-requester valid/ready handshakes and launches each byte into the transmitter with a one-cycle `txDv` pulse. It then holds the transmitter until its `txDone` pulse before granting again. It sits between the command/telemetry sources and the UART transmitter, and drives that transmitter's `txDv`/`incomingByte` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `GW`, default `$clog2(NUM_REQ)`: grant index width (derived; do not override).
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `reqValid`  in  NUM_REQ  requester i has a byte.
- `reqData`  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- `reqLast`  in  NUM_REQ  byte is last of a packet (used only with lock feature).
- `reqReady`  out  NUM_REQ  one-hot; byte of requester i accepted this cycle.
- `txDv`  out  1  one-cycle launch pulse to transmitter.
- `txData`  out  8  byte to transmitter; stable from launch until `txDone`.
- `txActive`  in  1  transmitter busy flag.
- `txDone`  in  1  transmitter one-cycle completion pulse.
- `grantId`  out  GW  index of current/last granted requester.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, plus HOLD when the lock feature is compiled in.
- IDLE:
  - Candidate = first set `reqValid` bit, searching circularly from `lastGrant+1`.
  - If a candidate exists and `txActive==0`: `reqReady[cand]=1` combinationally this cycle, latch `reqData[cand]` into `txData`, set `grantId=cand`, go to LAUNCH.
  - If `txActive==1`: grant nothing and stay in IDLE.
- LAUNCH: `txDv=1` for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - `txDv=0`; `txData` holds its value.
  - On `txDone==1`: `lastGrant<=grantId`, go to IDLE (or HOLD, see Configuration).
- Requesters hold `reqValid`/`reqData` stable until `reqReady`. Dropping `reqValid` before grant is legal; that requester is simply skipped.
- At most one `reqReady` bit is high in any cycle, and only in IDLE (or HOLD).
- `txDone` seen outside WAIT_DONE is ignored.
- Reset values: state IDLE, `reqReady=0`, `txDv=0`, `txData=8'h00`, `grantId=0`, `busy=0`, `lastGrant=NUM_REQ-1`, so requester 0 has highest priority after reset.
- Reset mid-operation: the arbiter returns to IDLE immediately. The transmitter has no reset, so the `txActive==0` gate blocks any new launch until an in-flight frame ends.

## Timing
- Accept-to-launch: `reqReady` in cycle N, `txDv` in cycle N+1.
- Minimum gap between grants: `txDone` in cycle M, next `reqReady` no earlier than M+1.
- No combinational path from `txDone`/`txActive` to `txDv`; `reqReady` depends combinationally on `reqValid`, state and `txActive`.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.

## Configuration
- Macro: `UART_TX_ARB_LOCK_EN`.
- Defined (packet lock):
  - After `txDone`, if the transmitted byte had `reqLast==0`, go to HOLD instead of IDLE.
  - HOLD serves only `grantId`. When `reqValid[grantId]` is high and `txActive==0`: assert `reqReady[grantId]`, latch the byte, go to LAUNCH. Other requesters wait.
  - `lastGrant` advances only after a `reqLast==1` byte completes.
  - `reqLast` is sampled together with `reqData` at accept.
- Undefined: HOLD does not exist, `reqLast` is ignored, and every byte is re-arbitrated.

## Structure
- Shared package `uart_pkg`: the state enum type (`logic [2:0]`, IDLE=0, LAUNCH=1, WAIT_DONE=2, HOLD=3) and the default `NUM_REQ` constant.
- One sub-module, `rr_picker`: combinational circular first-one search over `reqValid` starting at `lastGrant+1`, returning `found` and an index.
- State register, data latch and handshake logic live in `uart_tx_arbiter`.

## Test plan
- Single requester: `reqValid=4'b0001`, `reqData[7:0]=8'hA5`, idle transmitter → `reqReady[0]` in cycle N, `txDv` pulse in N+1 with `txData=8'hA5`, next grant only after `txDone`.
- All four requesters continuously valid with bytes 8'h10..8'h13 → `txData` order 10,11,12,13,10; exactly one `txDv` per `txDone`.
- Transmitter busy: `txActive=1` held for 20 cycles with `reqValid=4'b0100` → no `reqReady` and no `txDv` until the cycle after `txActive` falls.
- Reset asserted in WAIT_DONE with `txActive` still high → outputs return to reset values next cycle; no launch until `txActive==0`; then requester 0 wins over requester 2.
- `txDone` pulse injected in IDLE with no requests → no state change, `busy` stays 0.
- With `UART_TX_ARB_LOCK_EN`: requester 1 sends 3 bytes (`reqLast` high on the third) while requester 2 is valid → requester 1's bytes go out back-to-back, then requester 2 is granted.
